mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the datapath/cache request path.
- Merges the instruction-fetch request stream and the data load/store request stream onto the single-ported RAM interface.
- Registered two-way arbiter FSM:
  - data requests have priority;
  - a bounded-starvation guard protects instruction fetch;
  - a per-access timeout and RAM-error capture are included.
- Returns per-side wait and load data.

Parameters:
- MAX_D_STREAK, 4: max consecutive data grants while an instruction request is pending.
- TIMEOUT, 64: cycles a granted access may remain unfinished before forced completion.
- ERR_WORD, 32'hBAD1BAD1: load value returned on error or timeout.

Ports:
- CLK  in  1  single clock, rising edge.
- nRST  in  1  asynchronous, active-high reset. The name is kept per codebase convention; 1 = reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iwait  out  1  0 only in the cycle the instruction access completes.
- iload  out  32  instruction data, valid when iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request. dREN and dWEN are never both 1.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  0 only in the cycle the data access completes.
- dload  out  32  read data, valid when dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- mem_err  out  1  sticky error/timeout flag.

Behaviour:
- States:
  - ARB: no RAM strobes.
  - I_ACC: ramREN=1, ramaddr=iaddr.
  - D_ACC: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
- Reset (async, immediate):
  - state=ARB, streak=0, tcount=0, mem_err=0;
  - iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
  - Reset mid-access drops the strobes in the same cycle; the requester must re-issue.
- ARB transitions:
  - (dREN|dWEN) and not (iREN and streak==MAX_D_STREAK) -> D_ACC.
  - else iREN -> I_ACC.
  - else stay in ARB.
  - Simultaneous i+d requests normally grant data first.
- Access states, on each cycle:
  - ramstate==ACCESS: the granted side's wait=0 for exactly that cycle, load = ramload combinationally; next state ARB.
  - ramstate==ERROR, or tcount reaches TIMEOUT-1: forced completion, wait=0, load=ERR_WORD, mem_err<=1; next state ARB.
  - Otherwise hold; tcount increments (saturating). tcount is cleared on entry to each access state.
- Latency:
  - request seen at cycle 0 in ARB;
  - strobes asserted at cycle 1;
  - completion at the first ACCESS cycle;
  - minimum 2 cycles request-to-wait-low.
  - One ARB turnaround cycle always separates accesses.
- Streak counter:
  - +1 on each D_ACC completion while iREN=1 (saturating at MAX_D_STREAK);
  - cleared on each I_ACC completion or when iREN=0 in ARB.
- Request withdrawal: if the granted request drops before completion, return to ARB next cycle with no wait pulse and mem_err unchanged.
- Width rules: addresses and data are passed unmodified. tcount is $clog2(TIMEOUT+1) bits; streak is $clog2(MAX_D_STREAK+1) bits.
- mem_err is cleared only by reset.
- Non-granted side: wait=1, load=0.

Decomposition:
- cpu_types_pkg holds:
  - ramstate_t (FREE/BUSY/ACCESS/ERROR);
  - arb_state_t (ARB/I_ACC/D_ACC);
  - ERR_WORD default constant;
  - word_t for all 32-bit buses.
- Single module; no sub-module is natural. Keep the FSM, streak counter and timeout counter in one file.

Test Plan:
- Reset: hold nRST=1 with iREN=1 -> ramREN=0, iwait=dwait=1, mem_err=0. Assert nRST mid-D_ACC -> ramWEN falls the same cycle.
- Lone fetch: iREN=1, iaddr=0x40, RAM BUSY 2 cycles then ACCESS with ramload=0x8C220004 -> ramREN cycles 1-3, iwait=0 and iload=0x8C220004 at cycle 3 only.
- Simultaneous: iREN=1 and dREN=1 (daddr=0x100) at cycle 0 -> D_ACC first, dwait low, ARB turnaround, then I_ACC with iaddr.
- Starvation guard: MAX_D_STREAK=2, iREN and dWEN held continuously, zero-latency RAM -> grant order D, D, I, D, D, I.
- Store: dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF until ACCESS, dwait=0 one cycle.
- Fault: ramstate=ERROR during I_ACC -> iload=0xBAD1BAD1, iwait=0, mem_err=1 and stays set. With TIMEOUT=8 and RAM stuck BUSY -> forced completion 8 cycles after the grant.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus words, RAM handshake states, arbiter states.
// Imported by the memory arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB   = 2'd0;
    localparam arb_state_t I_ACC = 2'd1;
    localparam arb_state_t D_ACC = 2'd2;

    localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-way instruction/data arbiter onto a single-ported RAM.
// Ports: CLK/nRST (async, 1 = reset); i-side iREN/iaddr -> iwait/iload;
// d-side dREN/dWEN/daddr/dstore -> dwait/dload; RAM side ramREN/ramWEN/
// ramaddr/ramstore -> ramload/ramstate; mem_err sticky error/timeout flag.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int    MAX_D_STREAK = 4,
    parameter int    TIMEOUT      = 64,
    parameter word_t ERR_WORD     = ERR_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    output logic        iwait,
    output word_t       iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        dwait,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT      = TW'(TIMEOUT);

    arb_state_t     state_q, state_d;
    logic [SW-1:0]  streak_q, streak_d;
    logic [TW-1:0]  tcount_q, tcount_d;
    logic           err_q, err_d;

    logic d_req;
    logic ram_ok;
    logic ram_fault;

    assign d_req     = dREN | dWEN;
    assign ram_ok    = (ramstate == RAM_ACCESS);
    // Forced completion: RAM reported an error or the access ran too long.
    assign ram_fault = (ramstate == RAM_ERROR) || (tcount_q == T_LAST);
    assign mem_err   = err_q;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q  <= ARB;
            streak_q <= '0;
            tcount_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tcount_q <= tcount_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        tcount_d = tcount_q;
        err_d    = err_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state_q)
            ARB: begin
                tcount_d = '0;
                if (!iREN) streak_d = '0;
                // Data wins unless fetch has already waited out a full streak.
                if (d_req && !(iREN && streak_q == STREAK_MAX)) begin
                    state_d = D_ACC;
                end else if (iREN) begin
                    state_d = I_ACC;
                end
            end
            I_ACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = ARB;
                end else if (ram_ok || ram_fault) begin
                    iwait    = 1'b0;
                    iload    = ram_ok ? ramload : ERR_WORD;
                    err_d    = err_q | ~ram_ok;
                    streak_d = '0;
                    state_d  = ARB;
                end else if (tcount_q != T_SAT) begin
                    tcount_d = tcount_q + TW'(1);
                end
            end
            D_ACC: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    state_d = ARB;
                end else if (ram_ok || ram_fault) begin
                    dwait   = 1'b0;
                    dload   = ram_ok ? ramload : ERR_WORD;
                    err_d   = err_q | ~ram_ok;
                    state_d = ARB;
                    if (iREN && streak_q != STREAK_MAX) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (tcount_q != T_SAT) begin
                    tcount_d = tcount_q + TW'(1);
                end
            end
            default: state_d = ARB;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized requester/RAM run checked against a transaction-level model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int    MAXS = 2;
    localparam int    TMO  = 8;
    localparam word_t EW   = 32'hBAD1BAD1;

    logic       CLK = 1'b0;
    logic       nRST = 1'b1;
    logic       iREN = 1'b0;
    logic       dREN = 1'b0;
    logic       dWEN = 1'b0;
    word_t      iaddr = '0;
    word_t      daddr = '0;
    word_t      dstore = '0;
    word_t      ramload = '0;
    logic [1:0] ramstate = 2'd0;

    logic  iwait, dwait, ramREN, ramWEN, mem_err;
    word_t iload, dload, ramaddr, ramstore;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .MAX_D_STREAK (MAXS),
        .TIMEOUT      (TMO),
        .ERR_WORD     (EW)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .mem_err  (mem_err)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench just after a rising edge with reset released:
    // the caller's next input settings form "cycle 0".
    task automatic do_reset;
        nRST = 1'b1;
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        ramstate = RAM_FREE;
        tick;
        nRST = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b1;
        iREN = 1'b1;
        tick;
        tick;
        checks++;
        if ({ramREN, ramWEN, iwait, dwait, mem_err} !== 5'b00110) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b",
                     {ramREN, ramWEN, iwait, dwait, mem_err}, 5'b00110);
        end
        checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
            failures++;
            $display("FAIL reset_buses got=%h/%h/%h/%h exp=0",
                     ramaddr, ramstore, iload, dload);
        end
        iREN = 1'b0;
        nRST = 1'b0;
        // Reset asserted mid data write must drop the strobe at once.
        do_reset;
        dWEN = 1'b1;
        daddr = 32'h10;
        dstore = 32'h5;
        tick;
        ramstate = RAM_BUSY;
        #1;
        checks++;
        if (ramWEN !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre ramWEN got=%b exp=1", ramWEN);
        end
        nRST = 1'b1;
        #1;
        checks++;
        if ({ramWEN, ramREN, ramaddr} !== 34'd0) begin
            failures++;
            $display("FAIL rst_mid_drop got=%b%b %h exp=00 0",
                     ramWEN, ramREN, ramaddr);
        end
        dWEN = 1'b0;
        ramstate = RAM_FREE;
        tick;
        nRST = 1'b0;
    endtask

    task automatic test_lone_fetch;
        do_reset;
        iREN = 1'b1;
        iaddr = 32'h40;
        #1;
        checks++;
        if ({ramREN, iwait} !== 2'b01) begin
            failures++;
            $display("FAIL fetch_c0 got=%b exp=01", {ramREN, iwait});
        end
        for (int c = 1; c <= 3; c++) begin
            tick;
            ramstate = (c == 3) ? RAM_ACCESS : RAM_BUSY;
            ramload = (c == 3) ? 32'h8C220004 : 32'h0;
            #1;
            checks++;
            if ({ramREN, ramaddr, iwait, dwait} !== {1'b1, 32'h40, c != 3, 1'b1}) begin
                failures++;
                $display("FAIL fetch_c%0d got=%b %h %b%b", c,
                         ramREN, ramaddr, iwait, dwait);
            end
        end
        checks++;
        if (iload !== 32'h8C220004) begin
            failures++;
            $display("FAIL fetch_data got=%h exp=8c220004", iload);
        end
        tick;
        iREN = 1'b0;
        ramstate = RAM_FREE;
        #1;
        checks++;
        if ({ramREN, iwait, iload} !== {2'b01, 32'h0}) begin
            failures++;
            $display("FAIL fetch_after got=%b%b %h exp=01 0",
                     ramREN, iwait, iload);
        end
    endtask

    task automatic test_simultaneous;
        do_reset;
        iREN = 1'b1;
        iaddr = 32'h44;
        dREN = 1'b1;
        daddr = 32'h100;
        tick;
        ramstate = RAM_ACCESS;
        ramload = 32'h11;
        #1;
        checks++;
        if ({ramREN, ramaddr, dwait, dload, iwait} !== {1'b1, 32'h100, 1'b0, 32'h11, 1'b1}) begin
            failures++;
            $display("FAIL simul_data got=%b %h %b %h %b",
                     ramREN, ramaddr, dwait, dload, iwait);
        end
        tick;
        dREN = 1'b0;
        ramstate = RAM_FREE;
        #1;
        checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            failures++;
            $display("FAIL simul_turn got=%b exp=0011",
                     {ramREN, ramWEN, iwait, dwait});
        end
        tick;
        ramstate = RAM_ACCESS;
        ramload = 32'h22;
        #1;
        checks++;
        if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h44, 1'b0, 32'h22}) begin
            failures++;
            $display("FAIL simul_fetch got=%b %h %b %h",
                     ramREN, ramaddr, iwait, iload);
        end
        tick;
        iREN = 1'b0;
        ramstate = RAM_FREE;
    endtask

    task automatic test_starvation;
        int n;
        int got [6];
        int exp_g;
        n = 0;
        for (int g = 0; g < 6; g++) got[g] = 0;
        do_reset;
        iREN = 1'b1;
        iaddr = 32'h40;
        dWEN = 1'b1;
        daddr = 32'h80;
        dstore = 32'h1;
        ramstate = RAM_ACCESS;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if ((ramREN || ramWEN) && n < 6) begin
                got[n] = ramWEN ? 2 : 1;
                n++;
            end
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL starve_count got=%0d exp=6", n);
        end
        for (int g = 0; g < 6; g++) begin
            // Every (MAXS+1)-th grant goes to the held fetch: D D I D D I.
            exp_g = (g % (MAXS + 1) == MAXS) ? 1 : 2;
            checks++;
            if (got[g] != exp_g) begin
                failures++;
                $display("FAIL starve_grant%0d got=%0d exp=%0d (1=I 2=D)",
                         g, got[g], exp_g);
            end
        end
        iREN = 1'b0;
        dWEN = 1'b0;
        ramstate = RAM_FREE;
        tick;
    endtask

    task automatic test_store;
        do_reset;
        dWEN = 1'b1;
        daddr = 32'h200;
        dstore = 32'hDEADBEEF;
        for (int c = 1; c <= 3; c++) begin
            tick;
            ramstate = (c == 3) ? RAM_ACCESS : RAM_BUSY;
            #1;
            checks++;
            if ({ramREN, ramWEN, ramaddr, ramstore, dwait} !==
                {2'b01, 32'h200, 32'hDEADBEEF, c != 3}) begin
                failures++;
                $display("FAIL store_c%0d got=%b%b %h %h %b", c,
                         ramREN, ramWEN, ramaddr, ramstore, dwait);
            end
        end
        tick;
        dWEN = 1'b0;
        ramstate = RAM_FREE;
        #1;
        checks++;
        if ({ramWEN, dwait} !== 2'b01) begin
            failures++;
            $display("FAIL store_after got=%b exp=01", {ramWEN, dwait});
        end
    endtask

    task automatic test_withdraw;
        do_reset;
        dREN = 1'b1;
        daddr = 32'h20;
        tick;
        ramstate = RAM_BUSY;
        tick;
        dREN = 1'b0;
        ramstate = RAM_ACCESS;
        #1;
        checks++;
        if ({ramREN, dwait} !== 2'b01) begin
            failures++;
            $display("FAIL withdraw_nopulse got=%b exp=01", {ramREN, dwait});
        end
        tick;
        ramstate = RAM_FREE;
        #1;
        checks++;
        if ({ramREN, ramWEN, dwait, mem_err} !== 4'b0010) begin
            failures++;
            $display("FAIL withdraw_arb got=%b exp=0010",
                     {ramREN, ramWEN, dwait, mem_err});
        end
    endtask

    task automatic test_fault;
        int done_at;
        word_t ld;
        do_reset;
        iREN = 1'b1;
        iaddr = 32'h80;
        tick;
        ramstate = RAM_BUSY;
        tick;
        ramstate = RAM_ERROR;
        #1;
        checks++;
        if ({iwait, iload, mem_err} !== {1'b0, EW, 1'b0}) begin
            failures++;
            $display("FAIL fault_err got=%b %h %b exp=0 %h 0",
                     iwait, iload, mem_err, EW);
        end
        tick;
        iREN = 1'b0;
        ramstate = RAM_FREE;
        repeat (4) tick;
        checks++;
        if (mem_err !== 1'b1) begin
            failures++;
            $display("FAIL fault_sticky got=%b exp=1", mem_err);
        end
        // RAM stuck busy: forced completion TMO cycles after the grant.
        do_reset;
        done_at = -1;
        ld = '0;
        dREN = 1'b1;
        daddr = 32'h300;
        ramstate = RAM_BUSY;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (dwait == 1'b0 && done_at < 0) begin
                done_at = c;
                ld = dload;
            end
        end
        checks++;
        if (done_at != TMO) begin
            failures++;
            $display("FAIL timeout_cycle got=%0d exp=%0d", done_at, TMO);
        end
        checks++;
        if ({ld, mem_err} !== {EW, 1'b1}) begin
            failures++;
            $display("FAIL timeout_data got=%h %b exp=%h 1", ld, mem_err, EW);
        end
        dREN = 1'b0;
        ramstate = RAM_FREE;
    endtask

    task automatic test_random;
        word_t      mem [256];
        int         side;
        int         grant;
        int         lat;
        int         streak;
        logic       erry;
        logic       err_exp;
        logic       i_pend, d_pend, d_wr;
        word_t      ia, da, dd, expv;
        logic [1:0] rs;
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        side = 0;
        grant = 0;
        lat = 0;
        streak = 0;
        erry = 1'b0;
        err_exp = 1'b0;
        i_pend = 1'b0;
        d_pend = 1'b0;
        d_wr = 1'b0;
        ia = '0;
        da = '0;
        dd = '0;
        do_reset;
        for (int c = 0; c < 400; c++) begin
            if (c != 0) tick;
            if (grant != 0) begin
                side = grant;
                grant = 0;
                lat = $urandom_range(0, 3);
                erry = ($urandom_range(0, 15) == 0);
            end
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                ia = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                d_wr = ($urandom_range(0, 1) == 1);
                da = $urandom;
                dd = $urandom;
            end
            iREN = i_pend;
            iaddr = ia;
            dREN = d_pend && !d_wr;
            dWEN = d_pend && d_wr;
            daddr = da;
            dstore = dd;
            ramload = $urandom;
            if (side == 0) begin
                ramstate = RAM_FREE;
                #1;
                checks++;
                if ({ramREN, ramWEN, iwait, dwait, mem_err} !== {4'b0011, err_exp}) begin
                    failures++;
                    $display("FAIL rand_idle c=%0d got=%b exp=%b", c,
                             {ramREN, ramWEN, iwait, dwait, mem_err},
                             {4'b0011, err_exp});
                end
                if (!i_pend) streak = 0;
                if (d_pend && !(i_pend && streak == MAXS)) grant = 2;
                else if (i_pend) grant = 1;
            end else begin
                if (lat > 0) begin
                    rs = RAM_BUSY;
                    lat--;
                end else begin
                    rs = erry ? RAM_ERROR : RAM_ACCESS;
                end
                expv = (side == 1) ? mem[ia[7:0]] : mem[da[7:0]];
                if (rs == RAM_ACCESS) ramload = expv;
                if (rs == RAM_ERROR) expv = EW;
                ramstate = rs;
                #1;
                checks++;
                if (mem_err !== err_exp) begin
                    failures++;
                    $display("FAIL rand_memerr c=%0d got=%b exp=%b",
                             c, mem_err, err_exp);
                end
                checks++;
                if (side == 1) begin
                    if ({ramREN, ramWEN, ramaddr} !== {2'b10, ia}) begin
                        failures++;
                        $display("FAIL rand_istrobe c=%0d got=%b%b %h exp=10 %h",
                                 c, ramREN, ramWEN, ramaddr, ia);
                    end
                end else begin
                    if ({ramREN, ramWEN, ramaddr} !== {!d_wr, d_wr, da} ||
                        (d_wr && ramstore !== dd)) begin
                        failures++;
                        $display("FAIL rand_dstrobe c=%0d got=%b%b %h %h exp=%b%b %h %h",
                                 c, ramREN, ramWEN, ramaddr, ramstore,
                                 !d_wr, d_wr, da, dd);
                    end
                end
                checks++;
                if (rs == RAM_BUSY) begin
                    if ({iwait, dwait} !== 2'b11) begin
                        failures++;
                        $display("FAIL rand_busy c=%0d got=%b exp=11",
                                 c, {iwait, dwait});
                    end
                end else if (side == 1) begin
                    if ({iwait, dwait, iload} !== {2'b01, expv}) begin
                        failures++;
                        $display("FAIL rand_idone c=%0d got=%b%b %h exp=01 %h",
                                 c, iwait, dwait, iload, expv);
                    end
                    i_pend = 1'b0;
                    streak = 0;
                end else begin
                    if ({dwait, iwait} !== 2'b01 ||
                        ((!d_wr || erry) && dload !== expv)) begin
                        failures++;
                        $display("FAIL rand_ddone c=%0d got=%b%b %h exp=01 %h",
                                 c, dwait, iwait, dload, expv);
                    end
                    if (d_wr && !erry) mem[da[7:0]] = dd;
                    if (i_pend && streak < MAXS) streak++;
                    d_pend = 1'b0;
                end
                if (rs != RAM_BUSY) begin
                    if (erry) err_exp = 1'b1;
                    side = 0;
                end
            end
        end
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        ramstate = RAM_FREE;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_lone_fetch;
        test_simultaneous;
        test_starvation;
        test_store;
        test_withdraw;
        test_fault;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
